axi_xbar_drain_ctrl: RTL and testbench
======================================

Name: axi_xbar_drain_ctrl

Overview:
- Drain-and-clear sequencer for the clearable AXI crossbar.
- Tracks outstanding write and read transactions on every crossbar slave port.
- On a clear request it gates new AW/AR requests, waits for in-flight transactions to drain (bounded by a timeout), pulses the crossbar clear, then holds the acknowledge.
- Sits beside the crossbar; the wrapper ANDs each port's AW/AR valid and ready with the inverted gate outputs.

Parameters:
- NumSlvPorts, 4, number of crossbar slave ports tracked.
- MaxPending, 24, maximum outstanding transactions per port and direction; counter width is $clog2(MaxPending+1).
- TimeoutCycles, 1024, maximum number of DRAIN cycles before a forced clear; 0 disables the timeout; counter width is $clog2(TimeoutCycles+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clr_i  in  1  clear request, level; held until clr_ack_o is seen.
- aw_hs_i  in  NumSlvPorts  AW valid&ready handshake per port, post-gating.
- b_hs_i  in  NumSlvPorts  B valid&ready handshake per port.
- ar_hs_i  in  NumSlvPorts  AR valid&ready handshake per port, post-gating.
- r_last_hs_i  in  NumSlvPorts  R valid&ready&last per port.
- gate_aw_o  out  NumSlvPorts  1 = block new AW on this port.
- gate_ar_o  out  NumSlvPorts  1 = block new AR on this port.
- xbar_clr_o  out  1  one-cycle clear pulse to the crossbar.
- clr_ack_o  out  1  clear complete.
- busy_o  out  1  FSM not in IDLE.
- timeout_o  out  1  sticky: last clear was forced by the timeout.
- err_o  out  1  sticky: counter underflow observed.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - FSM goes to IDLE.
  - All counters are 0.
  - All outputs are 0.
  - Reset mid-sequence aborts immediately, with no xbar_clr_o pulse.
- Per-port counters wcnt[p] and rcnt[p]:
  - wcnt[p]: +1 on aw_hs_i[p], -1 on b_hs_i[p].
  - rcnt[p]: +1 on ar_hs_i[p], -1 on r_last_hs_i[p].
  - Increment and decrement in the same cycle leave the count unchanged.
  - A decrement at 0 leaves the count at 0 and sets err_o.
- Saturation backpressure:
  - gate_aw_o[p]=1 whenever wcnt[p]==MaxPending.
  - gate_ar_o[p]=1 whenever rcnt[p]==MaxPending.
  - This applies in every state.
- FSM states: IDLE, DRAIN, CLEAR, ACK.
- IDLE:
  - Gates are driven only by saturation.
  - clr_i=1 moves to DRAIN next cycle.
  - Handshakes in the same cycle as the transition are still counted.
- DRAIN:
  - All gate outputs are 1.
  - The timeout counter increments each cycle.
  - When all counters are 0, computed from registered values at the clock edge, go to CLEAR.
  - Else, if TimeoutCycles!=0 and the timeout counter reaches TimeoutCycles, go to CLEAR and set timeout_o.
  - If clr_i drops in DRAIN, the sequence still completes; no abort.
- CLEAR:
  - xbar_clr_o=1 for exactly one cycle; gates stay 1.
  - All wcnt/rcnt and the timeout counter are zeroed at exit.
  - Handshakes seen in this cycle are discarded.
  - Next state is ACK.
- ACK:
  - clr_ack_o=1 and gates stay 1 while clr_i=1.
  - When clr_i=0, return to IDLE next cycle with clr_ack_o=0.
  - If clr_i is already 0 on entry, ACK lasts exactly one cycle.
- Latency: clr_i rising with idle ports gives DRAIN at +1, xbar_clr_o at +2, clr_ack_o at +3.
- Sticky flags:
  - timeout_o is cleared at the next entry to DRAIN.
  - err_o is cleared only by reset.
- busy_o = (state != IDLE).
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

Test Plan:
- Idle clear: no traffic, clr_i=1 at cycle 0 -> gates=all 1 at cycle 1, xbar_clr_o pulse at cycle 2, clr_ack_o=1 from cycle 3; clr_i=0 at cycle 5 -> IDLE, ack=0 at cycle 6.
- Drain: 3 AW on port 1 and 2 AR on port 3 outstanding; clr_i=1; return 3 B and 2 R-last over 10 cycles -> xbar_clr_o exactly one cycle after the final decrement is registered; timeout_o=0.
- Timeout: TimeoutCycles=16, 1 AW on port 0 never answered -> xbar_clr_o 17 cycles after DRAIN entry, timeout_o=1, wcnt[0]=0 afterwards.
- Saturation: MaxPending=4, 4 AR on port 2 with no R -> gate_ar_o[2]=1 and other gates 0; one R-last -> gate_ar_o[2]=0 next cycle; simultaneous AR and R-last at count 3 -> count stays 3.
- Underflow: b_hs_i[1] with wcnt[1]=0 -> err_o=1 sticky, wcnt[1] stays 0.
- Reset mid-DRAIN: rst_i=1 for 1 cycle -> all outputs 0 immediately, state IDLE, counters 0, no xbar_clr_o pulse.

Source files
------------

// File: rtl/axi_xbar_drain_ctrl.sv
// ---------------------------------------------------------------------------
// axi_xbar_drain_ctrl
//
// Drain-and-clear sequencer for the clearable AXI crossbar. Counts outstanding
// write (AW->B) and read (AR->R-last) transactions on every crossbar slave
// port. On a clear request it gates new AW/AR requests, waits for the
// in-flight transactions to drain (bounded by an optional timeout), pulses
// the crossbar clear for one cycle, then holds the acknowledge until the
// request is withdrawn.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          clear request (level, held until clr_ack_o)
//   aw_hs_i        AW handshake per port (post-gating)
//   b_hs_i         B handshake per port
//   ar_hs_i        AR handshake per port (post-gating)
//   r_last_hs_i    R last-beat handshake per port
//   gate_aw_o      per port: block new AW (saturated or sequence active)
//   gate_ar_o      per port: block new AR (saturated or sequence active)
//   xbar_clr_o     one-cycle clear pulse to the crossbar
//   clr_ack_o      clear complete, held while clr_i stays high
//   busy_o         sequencer not idle
//   timeout_o      sticky: last clear was forced by the timeout
//   err_o          sticky: a counter underflow was observed
//
// All outputs decode from registers only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module axi_xbar_drain_ctrl #(
  parameter int unsigned NumSlvPorts   = 4,
  parameter int unsigned MaxPending    = 24,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic [NumSlvPorts-1:0] aw_hs_i,
  input  logic [NumSlvPorts-1:0] b_hs_i,
  input  logic [NumSlvPorts-1:0] ar_hs_i,
  input  logic [NumSlvPorts-1:0] r_last_hs_i,
  output logic [NumSlvPorts-1:0] gate_aw_o,
  output logic [NumSlvPorts-1:0] gate_ar_o,
  output logic                   xbar_clr_o,
  output logic                   clr_ack_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   err_o
);

  localparam int unsigned CntW = $clog2(MaxPending + 1);
  // A disabled timeout still needs a legal (non-zero) counter width.
  localparam int unsigned TmoW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxPending);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]        wcnt_q [NumSlvPorts];
  logic [CntW-1:0]        rcnt_q [NumSlvPorts];
  logic [TmoW-1:0]        tmo_q;
  logic                   all_zero;
  logic                   tmo_hit;
  logic [NumSlvPorts-1:0] w_uflow;
  logic [NumSlvPorts-1:0] r_uflow;

  // Saturating up/down step; simultaneous inc and dec cancel out.
  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                               input logic            inc,
                                               input logic            dec);
    cnt_next = cnt;
    if (inc && !dec && cnt != CntMax) cnt_next = cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt_next = cnt - 1'b1;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    all_zero = 1'b1;
    w_uflow  = '0;
    r_uflow  = '0;
    for (int p = 0; p < NumSlvPorts; p++) begin
      if (wcnt_q[p] != '0 || rcnt_q[p] != '0) all_zero = 1'b0;
      w_uflow[p] = b_hs_i[p] & ~aw_hs_i[p] & (wcnt_q[p] == '0);
      r_uflow[p] = r_last_hs_i[p] & ~ar_hs_i[p] & (rcnt_q[p] == '0);
    end
    tmo_hit = (TimeoutCycles != 0) && (tmo_q == TmoMax);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_i) state_d = DRAIN;
      // Normal drain has priority over the timeout when both hold.
      DRAIN:   if (all_zero || tmo_hit) state_d = CLEAR;
      CLEAR:   state_d = ACK;
      ACK:     if (!clr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the per-port counter arrays are reset like ordinary registers: the
  // drain decision and the saturation gates read them from the first cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumSlvPorts; p++) begin
        wcnt_q[p] <= '0;
        rcnt_q[p] <= '0;
      end
      err_o <= 1'b0;
    end else if (state_q == CLEAR) begin
      // The crossbar is being cleared: forget everything, including this
      // cycle's handshakes.
      for (int p = 0; p < NumSlvPorts; p++) begin
        wcnt_q[p] <= '0;
        rcnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NumSlvPorts; p++) begin
        wcnt_q[p] <= cnt_next(wcnt_q[p], aw_hs_i[p], b_hs_i[p]);
        rcnt_q[p] <= cnt_next(rcnt_q[p], ar_hs_i[p], r_last_hs_i[p]);
      end
      if ((|w_uflow) || (|r_uflow)) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state_q == DRAIN && TimeoutCycles != 0) tmo_q <= tmo_q + 1'b1;
      else                                        tmo_q <= '0;

      if (state_q == IDLE && clr_i)                        timeout_o <= 1'b0;
      else if (state_q == DRAIN && !all_zero && tmo_hit)   timeout_o <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < NumSlvPorts; p++) begin
      gate_aw_o[p] = (state_q != IDLE) || (wcnt_q[p] == CntMax);
      gate_ar_o[p] = (state_q != IDLE) || (rcnt_q[p] == CntMax);
    end
    xbar_clr_o = (state_q == CLEAR);
    clr_ack_o  = (state_q == ACK);
    busy_o     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_axi_xbar_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_xbar_drain_ctrl
//
// Self-checking bench for axi_xbar_drain_ctrl (4 ports, MaxPending=4,
// TimeoutCycles=16). A behavioural model tracks outstanding counts as plain
// integers and the clear sequence as a few flags; every output is compared
// with it after each clock edge. Directed scenarios add fixed-value checks on
// latencies and boundaries, and a randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_axi_xbar_drain_ctrl;

  localparam int NP = 4;
  localparam int MP = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [NP-1:0] aw_hs, b_hs, ar_hs, r_last_hs;
  logic [NP-1:0] gate_aw, gate_ar;
  logic          xbar_clr, clr_ack, busy, timeout, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: outstanding counts and where the clear sequence stands.
  int m_w[NP];
  int m_r[NP];
  bit m_drain, m_clear, m_ack;
  int m_age;
  bit m_tmo, m_err;

  axi_xbar_drain_ctrl #(
    .NumSlvPorts  (NP),
    .MaxPending   (MP),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .aw_hs_i    (aw_hs),
    .b_hs_i     (b_hs),
    .ar_hs_i    (ar_hs),
    .r_last_hs_i(r_last_hs),
    .gate_aw_o  (gate_aw),
    .gate_ar_o  (gate_ar),
    .xbar_clr_o (xbar_clr),
    .clr_ack_o  (clr_ack),
    .busy_o     (busy),
    .timeout_o  (timeout),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_w[p] = 0;
      m_r[p] = 0;
    end
    m_drain = 0; m_clear = 0; m_ack = 0;
    m_age = 0; m_tmo = 0; m_err = 0;
  endtask

  function automatic bit m_busy();
    return m_drain || m_clear || m_ack;
  endfunction

  // Outstanding count update for one port and direction.
  task automatic upd(inout int cnt, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (cnt < MP) cnt++;
    end else if (dec && !inc) begin
      if (cnt == 0) m_err = 1;
      else          cnt--;
    end
  endtask

  // One clock edge of the sequencer, derived from the behavioural rules.
  task automatic model_edge(input logic [NP-1:0] aw, b, ar, rl, input logic c);
    bit idle     = !m_busy();
    bit nothing  = 1;
    bit n_drain  = m_drain;
    bit n_clear  = 0;
    bit n_ack    = m_ack;
    for (int p = 0; p < NP; p++) if (m_w[p] != 0 || m_r[p] != 0) nothing = 0;
    if (m_drain) begin
      if (nothing) begin
        n_drain = 0; n_clear = 1;
      end else if (m_age == TO) begin
        n_drain = 0; n_clear = 1; m_tmo = 1;
      end else begin
        m_age++;
      end
    end
    if (m_clear) begin
      n_ack = 1;
      for (int p = 0; p < NP; p++) begin
        m_w[p] = 0;
        m_r[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        upd(m_w[p], aw[p], b[p]);
        upd(m_r[p], ar[p], rl[p]);
      end
    end
    if (m_ack && !c) n_ack = 0;
    if (idle && c) begin
      n_drain = 1; m_age = 0; m_tmo = 0;
    end
    m_drain = n_drain; m_clear = n_clear; m_ack = n_ack;
  endtask

  task automatic compare_all();
    logic [NP-1:0] e_aw, e_ar;
    for (int p = 0; p < NP; p++) begin
      e_aw[p] = m_busy() || (m_w[p] == MP);
      e_ar[p] = m_busy() || (m_r[p] == MP);
    end
    check("gate_aw",  32'(gate_aw),  32'(e_aw));
    check("gate_ar",  32'(gate_ar),  32'(e_ar));
    check("xbar_clr", 32'(xbar_clr), 32'(m_clear));
    check("clr_ack",  32'(clr_ack),  32'(m_ack));
    check("busy",     32'(busy),     32'(m_busy()));
    check("timeout",  32'(timeout),  32'(m_tmo));
    check("err",      32'(err),      32'(m_err));
  endtask

  // Drive one cycle of inputs, let the edge happen, compare 1 time unit later.
  task automatic step(input logic [NP-1:0] aw, b, ar, rl, input logic c);
    aw_hs = aw; b_hs = b; ar_hs = ar; r_last_hs = rl; clr = c;
    @(posedge clk);
    model_edge(aw, b, ar, rl, c);
    #1;
    compare_all();
  endtask

  task automatic idle_step(input logic c);
    step('0, '0, '0, '0, c);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gates"}, 32'({gate_aw, gate_ar}), 32'd0);
    check({tag, "_flags"}, 32'({xbar_clr, clr_ack, busy, timeout, err}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    aw_hs = '0; b_hs = '0; ar_hs = '0; r_last_hs = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Idle clear: gates at +1, clear pulse at +2, ack from +3, idle after drop.
    idle_step(1'b1);
    check("idle_gates", 32'({gate_aw, gate_ar}), 32'hFF);
    check("idle_noclr", 32'(xbar_clr), 32'd0);
    idle_step(1'b1);
    check("idle_clrpulse", 32'(xbar_clr), 32'd1);
    idle_step(1'b1);
    check("idle_ack", 32'({xbar_clr, clr_ack}), 32'b01);
    idle_step(1'b1);
    idle_step(1'b1);
    check("idle_ack_hold", 32'(clr_ack), 32'd1);
    idle_step(1'b0);
    check("idle_ack_drop", 32'({clr_ack, busy}), 32'd0);

    // Drain: 3 writes on port 1, 2 reads on port 3, answered while draining.
    step(4'b0010, '0, 4'b1000, '0, 1'b0);
    step(4'b0010, '0, 4'b1000, '0, 1'b0);
    step(4'b0010, '0, '0, '0, 1'b0);
    idle_step(1'b1);
    for (int i = 0; i < 10; i++) begin
      logic [NP-1:0] b, rl;
      b  = (i == 1 || i == 3 || i == 5) ? 4'b0010 : 4'b0000;
      rl = (i == 7 || i == 9) ? 4'b1000 : 4'b0000;
      step('0, b, '0, rl, 1'b1);
      check("drain_wait", 32'(xbar_clr), 32'd0);
    end
    idle_step(1'b1);
    check("drain_clr", 32'(xbar_clr), 32'd1);
    check("drain_no_tmo", 32'(timeout), 32'd0);
    idle_step(1'b1);
    idle_step(1'b0);

    // Timeout: one write on port 0 never answered.
    step(4'b0001, '0, '0, '0, 1'b0);
    idle_step(1'b1);
    for (int j = 1; j <= TO; j++) begin
      idle_step(1'b1);
      check("tmo_wait", 32'(xbar_clr), 32'd0);
    end
    idle_step(1'b1);
    check("tmo_clr", 32'({xbar_clr, timeout}), 32'b11);
    idle_step(1'b0);
    idle_step(1'b0);
    // Port 0 write count was zeroed: it takes exactly MP writes to saturate.
    for (int k = 1; k <= MP; k++) begin
      step(4'b0001, '0, '0, '0, 1'b0);
      check("tmo_wcnt0", 32'(gate_aw[0]), 32'(k == MP));
    end
    for (int k = 0; k < MP; k++) step('0, 4'b0001, '0, '0, 1'b0);

    // Saturation on port 2 reads.
    for (int k = 0; k < MP; k++) step('0, '0, 4'b0100, '0, 1'b0);
    check("sat_gate_ar", 32'(gate_ar), 32'b0100);
    check("sat_gate_aw", 32'(gate_aw), 32'd0);
    step('0, '0, '0, 4'b0100, 1'b0);
    check("sat_release", 32'(gate_ar), 32'd0);
    step('0, '0, 4'b0100, 4'b0100, 1'b0);
    check("sat_incdec", 32'(gate_ar), 32'd0);
    step('0, '0, 4'b0100, '0, 1'b0);
    check("sat_again", 32'(gate_ar), 32'b0100);
    for (int k = 0; k < MP; k++) step('0, '0, '0, 4'b0100, 1'b0);

    // Randomized traffic with clear requests, no underflow.
    begin
      bit req = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        logic [NP-1:0] aw, b, ar, rl;
        for (int p = 0; p < NP; p++) begin
          aw[p] = !(m_busy() || m_w[p] == MP) && ($urandom_range(0, 3) == 0);
          ar[p] = !(m_busy() || m_r[p] == MP) && ($urandom_range(0, 3) == 0);
          b[p]  = (m_w[p] > 0) && ($urandom_range(0, 5) == 0);
          rl[p] = (m_r[p] > 0) && ($urandom_range(0, 5) == 0);
        end
        if (!req && !m_busy() && $urandom_range(0, 29) == 0) req = 1;
        else if (req && m_ack && $urandom_range(0, 2) == 0) req = 0;
        else if (req && m_drain && $urandom_range(0, 49) == 0) req = 0;
        step(aw, b, ar, rl, req);
      end
      while (m_busy()) idle_step(1'b0);
      for (int p = 0; p < NP; p++) begin
        while (m_w[p] > 0 || m_r[p] > 0) begin
          logic [NP-1:0] one;
          one = '0;
          one[p] = 1'b1;
          step('0, (m_w[p] > 0) ? one : '0, '0, (m_r[p] > 0) ? one : '0, 1'b0);
        end
      end
    end

    // Underflow: B on port 1 with nothing outstanding.
    step('0, 4'b0010, '0, '0, 1'b0);
    check("uflow_err", 32'(err), 32'd1);
    idle_step(1'b0);
    check("uflow_sticky", 32'(err), 32'd1);
    for (int k = 1; k <= MP; k++) begin
      step(4'b0010, '0, '0, '0, 1'b0);
      check("uflow_wcnt1", 32'(gate_aw[1]), 32'(k == MP));
    end

    // Reset in the middle of DRAIN.
    idle_step(1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    check("mid_busy", 32'({busy, xbar_clr}), 32'b10);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_edge");
    rst = 1'b0;
    idle_step(1'b0);
    idle_step(1'b0);
    // Counters cleared by reset: an idle clear completes with minimum latency.
    idle_step(1'b1);
    idle_step(1'b1);
    check("post_reset_clr", 32'(xbar_clr), 32'd1);
    idle_step(1'b0);
    idle_step(1'b0);
    check("post_reset_idle", 32'({busy, clr_ack}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
